// File: rtl/proc_sequencer_if.sv
// proc_sequencer_if
//   Groups the sequencer's handshake and bus signals.
//   master: the sequencer (drives control outputs, samples start/prog/halt/dump_ready)
//   slave : the environment / datapath side (the mirror image)
//   Signals: start; prog_valid/prog_data/prog_ready (program load);
//            instr_addr/instr_data/instr_write/instr_read (instruction memory);
//            pc_reset/pc_write (PC register); initializing/ending (address muxes);
//            halt, run_cycle (run control); end_read_reg1/end_read_reg2/end_mem_addr,
//            dump_valid/dump_kind/dump_ready (dump handshake); done.
interface proc_sequencer_if;
    logic        start;
    logic        prog_valid;
    logic [31:0] prog_data;
    logic        prog_ready;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic        instr_write;
    logic        instr_read;
    logic        pc_reset;
    logic        pc_write;
    logic        initializing;
    logic        ending;
    logic        halt;
    logic [15:0] run_cycle;
    logic [4:0]  end_read_reg1;
    logic [4:0]  end_read_reg2;
    logic [31:0] end_mem_addr;
    logic        dump_valid;
    logic        dump_kind;
    logic        dump_ready;
    logic        done;

    modport master (
        input  start, prog_valid, prog_data, halt, dump_ready,
        output prog_ready, instr_addr, instr_data, instr_write, instr_read,
               pc_reset, pc_write, initializing, ending, run_cycle,
               end_read_reg1, end_read_reg2, end_mem_addr,
               dump_valid, dump_kind, done
    );

    modport slave (
        output start, prog_valid, prog_data, halt, dump_ready,
        input  prog_ready, instr_addr, instr_data, instr_write, instr_read,
               pc_reset, pc_write, initializing, ending, run_cycle,
               end_read_reg1, end_read_reg2, end_mem_addr,
               dump_valid, dump_kind, done
    );
endinterface

// File: rtl/proc_sequencer.sv
// proc_sequencer
//   Drives a load / run / dump sequence around a small processor datapath:
//   loads PROG_LEN program words into instruction memory, runs the processor
//   for up to RUN_CYCLES cycles (or until halt), dumps the 16 register pairs
//   and MEM_BYTES data-memory bytes, then reports done.
//   Ports: clk   - single clock, rising edge
//          reset - asynchronous, active-high
//          bus   - proc_sequencer_if.master (all handshake / control signals)
module proc_sequencer #(
    parameter int PROG_LEN   = 17,
    parameter int RUN_CYCLES = 50,
    parameter int MEM_BYTES  = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    proc_sequencer_if.master      bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DUMP_REG,
        DUMP_MEM,
        DONE
    } state_t;

    // Widths cover the full parameter ranges so no counter can wrap.
    localparam logic [9:0]  LAST_IDX  = 10'(PROG_LEN - 1);
    localparam logic [15:0] LAST_RUN  = 16'(RUN_CYCLES - 1);
    localparam logic [15:0] LAST_MEM  = 16'(MEM_BYTES - 1);
    localparam logic [3:0]  LAST_PAIR = 4'd15;

    state_t      state;
    logic [9:0]  loadIdx;
    logic [15:0] runCycle;
    logic [3:0]  pairIdx;
    logic [15:0] memAddr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            loadIdx  <= '0;
            runCycle <= '0;
            pairIdx  <= '0;
            memAddr  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state    <= LOAD;
                        loadIdx  <= '0;
                        runCycle <= '0;
                        pairIdx  <= '0;
                        memAddr  <= '0;
                    end
                end
                LOAD: begin
                    if (bus.prog_valid) begin
                        if (loadIdx == LAST_IDX) state <= RUN;
                        else                     loadIdx <= loadIdx + 10'd1;
                    end
                end
                RUN: begin
                    // The exit cycle does not count up, so run_cycle keeps
                    // the value it had in the final RUN cycle.
                    if (bus.halt || runCycle == LAST_RUN) begin
                        state   <= DUMP_REG;
                        pairIdx <= '0;
                    end else begin
                        runCycle <= runCycle + 16'd1;
                    end
                end
                DUMP_REG: begin
                    if (bus.dump_ready) begin
                        if (pairIdx == LAST_PAIR) begin
                            state   <= DUMP_MEM;
                            memAddr <= '0;
                        end else begin
                            pairIdx <= pairIdx + 4'd1;
                        end
                    end
                end
                DUMP_MEM: begin
                    if (bus.dump_ready) begin
                        if (memAddr == LAST_MEM) state <= DONE;
                        else                     memAddr <= memAddr + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Moore outputs decoded from the state register; instr_write is the one
    // combinational pass-through of prog_valid during LOAD.
    always_comb begin
        bus.prog_ready    = 1'b0;
        bus.instr_addr    = '0;
        bus.instr_data    = '0;
        bus.instr_write   = 1'b0;
        bus.instr_read    = 1'b0;
        bus.pc_reset      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.initializing  = 1'b0;
        bus.ending        = 1'b0;
        bus.end_read_reg1 = '0;
        bus.end_read_reg2 = '0;
        bus.end_mem_addr  = '0;
        bus.dump_valid    = 1'b0;
        bus.dump_kind     = 1'b0;
        bus.done          = 1'b0;
        bus.run_cycle     = runCycle;
        case (state)
            IDLE: begin
                bus.initializing = 1'b1;
                bus.pc_reset     = 1'b1;
            end
            LOAD: begin
                bus.prog_ready   = 1'b1;
                bus.instr_write  = bus.prog_valid;
                bus.instr_addr   = {20'd0, loadIdx, 2'b00};
                bus.instr_data   = bus.prog_data;
                bus.pc_reset     = 1'b1;
                bus.initializing = 1'b1;
            end
            RUN: begin
                bus.pc_write   = 1'b1;
                bus.instr_read = 1'b1;
            end
            DUMP_REG: begin
                bus.ending        = 1'b1;
                bus.dump_valid    = 1'b1;
                bus.end_read_reg1 = {pairIdx, 1'b0};
                bus.end_read_reg2 = {pairIdx, 1'b1};
            end
            DUMP_MEM: begin
                bus.ending       = 1'b1;
                bus.dump_valid   = 1'b1;
                bus.dump_kind    = 1'b1;
                bus.end_mem_addr = {16'd0, memAddr};
            end
            DONE: begin
                bus.done   = 1'b1;
                bus.ending = 1'b1;
            end
            default: begin
                bus.initializing = 1'b1;
                bus.pc_reset     = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_proc_sequencer.sv
module tb_proc_sequencer;

    localparam int PL = 3;
    localparam int RC = 10;
    localparam int MB = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    proc_sequencer_if bus();

    proc_sequencer #(
        .PROG_LEN  (PL),
        .RUN_CYCLES(RC),
        .MEM_BYTES (MB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    typedef enum int {M_IDLE, M_LOAD, M_RUN, M_DREG, M_DMEM, M_DONE} mphase_t;
    mphase_t mPh   = M_IDLE;
    int      mIdx  = 0;
    int      mRun  = 0;
    int      mPair = 0;
    int      mMem  = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mPh <= M_IDLE; mIdx <= 0; mRun <= 0; mPair <= 0; mMem <= 0;
        end else begin
            case (mPh)
                M_IDLE, M_DONE:
                    if (bus.start) begin
                        mPh <= M_LOAD; mIdx <= 0; mRun <= 0; mPair <= 0; mMem <= 0;
                    end
                M_LOAD:
                    if (bus.prog_valid) begin
                        if (mIdx + 1 == PL) mPh <= M_RUN;
                        else mIdx <= mIdx + 1;
                    end
                M_RUN:
                    if (bus.halt || mRun + 1 == RC) begin mPh <= M_DREG; mPair <= 0; end
                    else mRun <= mRun + 1;
                M_DREG:
                    if (bus.dump_ready) begin
                        if (mPair == 15) begin mPh <= M_DMEM; mMem <= 0; end
                        else mPair <= mPair + 1;
                    end
                M_DMEM:
                    if (bus.dump_ready) begin
                        if (mMem + 1 == MB) mPh <= M_DONE;
                        else mMem <= mMem + 1;
                    end
                default: mPh <= M_IDLE;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model
    typedef struct {
        logic pr, iw, ir, pcr, pcw, ini, endg, dv, dk, dn;
        logic [31:0] ia, id, ma;
        logic [4:0] r1, r2;
    } exp_t;

    always @(negedge clk) begin
        exp_t e;
        e = '{default: '0};
        case (mPh)
            M_IDLE: begin e.ini = 1; e.pcr = 1; end
            M_LOAD: begin
                e.pr = 1; e.iw = bus.prog_valid; e.ia = 32'(mIdx * 4);
                e.id = bus.prog_data; e.pcr = 1; e.ini = 1;
            end
            M_RUN:  begin e.pcw = 1; e.ir = 1; end
            M_DREG: begin e.endg = 1; e.dv = 1; e.r1 = 5'(2 * mPair); e.r2 = 5'(2 * mPair + 1); end
            M_DMEM: begin e.endg = 1; e.dv = 1; e.dk = 1; e.ma = 32'(mMem); end
            M_DONE: begin e.dn = 1; e.endg = 1; end
            default: ;
        endcase
        chk("prog_ready",    32'(bus.prog_ready),    32'(e.pr));
        chk("instr_write",   32'(bus.instr_write),   32'(e.iw));
        chk("instr_read",    32'(bus.instr_read),    32'(e.ir));
        chk("instr_addr",    bus.instr_addr,         e.ia);
        chk("instr_data",    bus.instr_data,         e.id);
        chk("pc_reset",      32'(bus.pc_reset),      32'(e.pcr));
        chk("pc_write",      32'(bus.pc_write),      32'(e.pcw));
        chk("initializing",  32'(bus.initializing),  32'(e.ini));
        chk("ending",        32'(bus.ending),        32'(e.endg));
        chk("run_cycle",     32'(bus.run_cycle),     32'(mRun));
        chk("end_read_reg1", 32'(bus.end_read_reg1), 32'(e.r1));
        chk("end_read_reg2", 32'(bus.end_read_reg2), 32'(e.r2));
        chk("end_mem_addr",  bus.end_mem_addr,       e.ma);
        chk("dump_valid",    32'(bus.dump_valid),    32'(e.dv));
        chk("dump_kind",     32'(bus.dump_kind),     32'(e.dk));
        chk("done",          32'(bus.done),          32'(e.dn));
    end

    // Capture of instruction-memory writes (address, data) as seen on the bus
    logic [31:0] wAddr[$];
    logic [31:0] wData[$];
    always @(negedge clk) begin
        if (bus.instr_write === 1'b1) begin
            wAddr.push_back(bus.instr_addr);
            wData.push_back(bus.instr_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] dWords[3];
        logic        pat[5];
        logic [31:0] memSeen[$];
        int runCnt;
        int lastRc;

        bus.start = 0; bus.prog_valid = 0; bus.prog_data = '0;
        bus.halt = 0; bus.dump_ready = 0;

        #1 reset = 1;
        tick(); tick();
        chk("rst_initializing", 32'(bus.initializing), 32'd1);
        chk("rst_pc_reset",     32'(bus.pc_reset),     32'd1);
        chk("rst_run_cycle",    32'(bus.run_cycle),    32'd0);
        chk("rst_done",         32'(bus.done),         32'd0);
        reset = 0;
        tick();

        // Straight three-word load
        dWords[0] = 32'hDEAD0001; dWords[1] = 32'h12345678; dWords[2] = 32'hCAFEF00D;
        bus.start = 1; tick(); bus.start = 0;
        wAddr.delete(); wData.delete();
        bus.prog_valid = 1;
        for (int i = 0; i < 3; i++) begin
            bus.prog_data = dWords[i];
            tick();
        end
        bus.prog_valid = 0;
        chk("load_pc_reset_run", 32'(bus.pc_reset), 32'd0);
        chk("load_pc_write_run", 32'(bus.pc_write), 32'd1);
        chk("load_nwrites", 32'(wAddr.size()), 32'd3);
        for (int i = 0; i < 3 && i < wAddr.size(); i++) begin
            chk("load_addr", wAddr[i], 32'(i * 4));
            chk("load_data", wData[i], dWords[i]);
        end

        // Full-length run, no halt
        runCnt = 0; lastRc = 0;
        for (int k = 0; k < 50 && bus.instr_read === 1'b1; k++) begin
            runCnt++;
            lastRc = int'(bus.run_cycle);
            tick();
        end
        chk("run_len",       32'(runCnt),             32'd10);
        chk("run_last",      32'(lastRc),             32'd9);
        chk("run_hold",      32'(bus.run_cycle),      32'd9);
        chk("dreg_ending",   32'(bus.ending),         32'd1);
        chk("dreg_reg1",     32'(bus.end_read_reg1),  32'd0);
        chk("dreg_reg2",     32'(bus.end_read_reg2),  32'd1);

        // Stall the register dump at pair 7
        bus.dump_ready = 1;
        for (int k = 0; k < 40 && bus.end_read_reg1 !== 5'd14; k++) tick();
        chk("dreg_reach_p7", 32'(bus.end_read_reg1), 32'd14);
        bus.dump_ready = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_reg1",  32'(bus.end_read_reg1), 32'd14);
            chk("stall_reg2",  32'(bus.end_read_reg2), 32'd15);
            chk("stall_valid", 32'(bus.dump_valid),    32'd1);
        end
        bus.dump_ready = 1;
        memSeen.delete();
        for (int k = 0; k < 60 && bus.done !== 1'b1; k++) begin
            if (bus.dump_kind === 1'b1 && bus.dump_valid === 1'b1) memSeen.push_back(bus.end_mem_addr);
            tick();
        end
        chk("done_reached", 32'(bus.done), 32'd1);
        chk("mem_beats", 32'(memSeen.size()), 32'd4);
        for (int i = 0; i < memSeen.size() && i < 4; i++) chk("mem_addr", memSeen[i], 32'(i));
        bus.dump_ready = 0;

        // Gappy load from DONE: valid pattern 1,0,1,0,1
        pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 0; pat[4] = 1;
        bus.start = 1; tick(); bus.start = 0;
        wAddr.delete(); wData.delete();
        for (int i = 0; i < 5; i++) begin
            bus.prog_valid = pat[i];
            bus.prog_data  = $urandom;
            tick();
        end
        bus.prog_valid = 0;
        chk("gap_nwrites", 32'(wAddr.size()), 32'd3);
        for (int i = 0; i < 3 && i < wAddr.size(); i++) chk("gap_addr", wAddr[i], 32'(i * 4));
        chk("gap_in_run", 32'(bus.instr_read), 32'd1);

        // Halt at run_cycle 4
        for (int k = 0; k < 20 && bus.run_cycle !== 16'd4; k++) tick();
        chk("halt_reach4", 32'(bus.run_cycle), 32'd4);
        bus.halt = 1; tick(); bus.halt = 0;
        chk("halt_rc",     32'(bus.run_cycle),  32'd4);
        chk("halt_ending", 32'(bus.ending),     32'd1);
        chk("halt_dvalid", 32'(bus.dump_valid), 32'd1);
        bus.halt = 1; tick(); bus.halt = 0; tick();
        chk("halt_rc_hold", 32'(bus.run_cycle), 32'd4);

        // Asynchronous reset in DUMP_MEM at address 2
        bus.dump_ready = 1;
        for (int k = 0; k < 60 && !(bus.dump_kind === 1'b1 && bus.end_mem_addr == 32'd2); k++) tick();
        chk("dmem_reach2", bus.end_mem_addr, 32'd2);
        #2 reset = 1;
        #1;
        chk("arst_init",    32'(bus.initializing), 32'd1);
        chk("arst_pcreset", 32'(bus.pc_reset),     32'd1);
        chk("arst_dvalid",  32'(bus.dump_valid),   32'd0);
        chk("arst_ending",  32'(bus.ending),       32'd0);
        chk("arst_rc",      32'(bus.run_cycle),    32'd0);
        chk("arst_maddr",   bus.end_mem_addr,      32'd0);
        tick(); reset = 0;
        bus.prog_valid = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_no_write", 32'(bus.instr_write), 32'd0);
            chk("idle_no_dump",  32'(bus.dump_valid),  32'd0);
        end
        wAddr.delete(); wData.delete();
        bus.start = 1; tick(); bus.start = 0;
        tick();
        chk("rerun_first_addr", (wAddr.size() > 0) ? wAddr[0] : 32'hFFFFFFFF, 32'd0);
        bus.prog_valid = 0;

        // Randomized traffic, including random resets
        for (int c = 0; c < 3000; c++) begin
            bus.start      = ($urandom % 6) == 0;
            bus.prog_valid = $urandom % 2;
            bus.prog_data  = $urandom;
            bus.halt       = ($urandom % 12) == 0;
            bus.dump_ready = ($urandom % 3) != 0;
            reset          = ($urandom % 400) == 0;
            tick();
        end
        reset = 0;
        tick();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/proc_sequencer.md
PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 Parameter PROG_LEN, default 17: instruction words to load, 1..1024.
REQ-002 Parameter RUN_CYCLES, default 50: maximum processor clock cycles in RUN, 1..65535.
REQ-003 Parameter MEM_BYTES, default 64: data-memory bytes to dump, 1..65536.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  begins a load/run/dump sequence; sampled only in IDLE or DONE.
REQ-007 prog_valid  in  1, prog_data  in  32, prog_ready  out  1: program-word handshake.
REQ-008 instr_addr  out  32, instr_data  out  32, instr_write  out  1, instr_read  out  1: instruction-memory port controls.
REQ-009 pc_reset  out  1, pc_write  out  1: PC register controls.
REQ-010 initializing  out  1, ending  out  1: datapath address-mux selects.
REQ-011 halt  in  1: early stop request from the datapath.
REQ-012 run_cycle  out  16: cycles elapsed in the current RUN.
REQ-013 end_read_reg1  out  5, end_read_reg2  out  5, end_mem_addr  out  32: dump addresses.
REQ-014 dump_valid  out  1, dump_kind  out  1 (0 = register pair, 1 = memory byte), dump_ready  in  1: dump handshake.
REQ-015 done  out  1: sequence complete.

Function
REQ-016 States SHALL be IDLE, LOAD, RUN, DUMP_REG, DUMP_MEM, DONE.
REQ-017 IDLE: initializing=1, pc_reset=1, all other outputs 0; start=1 -> LOAD with load index 0 and run_cycle 0.
REQ-018 LOAD: prog_ready=1; instr_write = prog_valid (combinational); instr_addr = index*4; instr_data = prog_data; instr_read=0; pc_reset=1; initializing=1.
REQ-019 LOAD: index SHALL increment on each accepted word; acceptance of word PROG_LEN-1 -> RUN on that edge; prog_valid=0 holds state and index.
REQ-020 RUN: initializing=0, pc_reset=0, pc_write=1, instr_read=1, prog_ready=0, instr_write=0.
REQ-021 RUN: run_cycle SHALL increment by 1 every cycle; exit to DUMP_REG when run_cycle==RUN_CYCLES-1 or halt=1; halt and the count limit in the same cycle give one transition.
REQ-022 DUMP_REG: ending=1, pc_write=0, instr_read=0, dump_valid=1, dump_kind=0; end_read_reg1 = 2*p and end_read_reg2 = 2*p+1 for pair p = 0..15.
REQ-023 DUMP_REG: p SHALL advance only when dump_valid and dump_ready; acceptance of p=15 -> DUMP_MEM with end_mem_addr 0.
REQ-024 DUMP_MEM: ending=1, dump_valid=1, dump_kind=1; end_mem_addr advances by 1 per accepted beat; acceptance of MEM_BYTES-1 -> DONE.
REQ-025 dump_ready=0 SHALL hold the dump addresses and dump_valid stable.
REQ-026 DONE: done=1, ending=1, dump_valid=0, pc_write=0; start=1 -> LOAD, clearing index, run_cycle, p and end_mem_addr.
REQ-027 start in LOAD, RUN, DUMP_REG or DUMP_MEM SHALL be ignored.
REQ-028 halt outside RUN SHALL be ignored.
REQ-029 run_cycle SHALL hold its final value through DUMP_REG, DUMP_MEM and DONE; it is cleared only on entry to LOAD or on reset.
REQ-030 Counters SHALL be sized so that no count wraps within parameter ranges.

Reset
REQ-031 reset=1 SHALL force IDLE immediately, regardless of clk.
REQ-032 Reset values: initializing=1, pc_reset=1; every other output 0; all counters 0.
REQ-033 Reset asserted mid-LOAD or mid-dump SHALL abort with no further instr_write or dump_valid; start is required to re-run.

Verification
REQ-034 PROG_LEN=3, start, then prog_valid for 3 cycles -> instr_write on addresses 0, 4, 8 with the supplied data; RUN entered the next cycle with pc_reset=0 and pc_write=1.
REQ-035 prog_valid toggled 1,0,1,0,1 with PROG_LEN=3 -> exactly 3 writes, addresses 0/4/8, no address skipped or repeated.
REQ-036 RUN_CYCLES=10, no halt -> RUN lasts 10 cycles, run_cycle ends at 9, then DUMP_REG shows reg1=0 and reg2=1 with ending=1.
REQ-037 halt pulsed at run_cycle=4 -> DUMP_REG on the next edge, run_cycle holds 4.
REQ-038 dump_ready low for 3 cycles at p=7 -> reg1=14 and reg2=15 held; after 16 pairs and MEM_BYTES=4 beats (addresses 0-3), done=1.
REQ-039 Asynchronous reset mid-DUMP_MEM at addr 2 -> outputs at reset values before the next edge; start re-runs the full sequence from LOAD index 0.
